// File: rtl/sbox_sched.sv
// Shares a pool of NUM_SBOX S-box lanes between the round state (16 bytes) and the key word (4
// bytes), with round-robin arbitration and valid/ready request and result channels.
module sbox_sched #(
    parameter int unsigned NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_in_valid,
    output logic         st_in_ready,
    input  logic [127:0] st_in_data,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out_data,
    input  logic         kw_in_valid,
    output logic         kw_in_ready,
    input  logic [31:0]  kw_in_data,
    output logic         kw_out_valid,
    input  logic         kw_out_ready,
    output logic [31:0]  kw_out_data,
    output logic         busy
);

    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4)) begin : g_bad_num_sbox
        $error("sbox_sched: NUM_SBOX must be 1, 2 or 4");
    end

    localparam int unsigned StBeats = 16 / NUM_SBOX;
    localparam int unsigned KwBeats = 4 / NUM_SBOX;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e        state_q, state_d;
    logic [3:0]    beat_q, beat_d;
    logic          owner_kw_q, owner_kw_d;
    logic          rr_kw_q, rr_kw_d;
    logic [127:0]  op_q, op_d;
    logic [127:0]  st_res_q, st_res_d;
    logic [31:0]   kw_res_q, kw_res_d;
    logic          gnt_kw, gnt_st;
    logic [3:0]    last_beat;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 in GF(2^8) (0 maps to 0), then the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int k = 0; k < 8; k++) begin
            if (k != 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
               ^ 8'h63;
    endfunction

    // Grant only from IDLE; rr breaks ties, a lone requester always wins.
    always_comb begin
        gnt_kw = 1'b0;
        gnt_st = 1'b0;
        if (state_q == StIdle && !rst) begin
            if (kw_in_valid && (!st_in_valid || rr_kw_q)) gnt_kw = 1'b1;
            else if (st_in_valid) gnt_st = 1'b1;
        end
    end

    assign last_beat = owner_kw_q ? 4'(KwBeats - 1) : 4'(StBeats - 1);

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        owner_kw_d = owner_kw_q;
        rr_kw_d    = rr_kw_q;
        op_d       = op_q;
        st_res_d   = st_res_q;
        kw_res_d   = kw_res_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_kw) begin
                    op_d       = {96'b0, kw_in_data};
                    owner_kw_d = 1'b1;
                    rr_kw_d    = 1'b0;
                    beat_d     = '0;
                    state_d    = StBusy;
                end else if (gnt_st) begin
                    op_d       = st_in_data;
                    owner_kw_d = 1'b0;
                    rr_kw_d    = 1'b1;
                    beat_d     = '0;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                for (int unsigned i = 0; i < NUM_SBOX; i++) begin
                    int unsigned idx;
                    logic [7:0]  sb;
                    idx = 32'(beat_q) * NUM_SBOX + i;
                    sb  = sbox(op_q[idx*8 +: 8]);
                    if (owner_kw_q) begin
                        if (idx < 4) kw_res_d[idx*8 +: 8] = sb;
                    end else begin
                        st_res_d[idx*8 +: 8] = sb;
                    end
                end
                beat_d = beat_q + 4'd1;
                if (beat_q == last_beat) state_d = StDone;
            end
            StDone: begin
                if (owner_kw_q ? kw_out_ready : st_out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            owner_kw_q <= 1'b0;
            rr_kw_q    <= 1'b1;
            op_q       <= '0;
            st_res_q   <= '0;
            kw_res_q   <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            owner_kw_q <= owner_kw_d;
            rr_kw_q    <= rr_kw_d;
            op_q       <= op_d;
            st_res_q   <= st_res_d;
            kw_res_q   <= kw_res_d;
        end
    end

    assign kw_in_ready  = gnt_kw;
    assign st_in_ready  = gnt_st;
    assign kw_out_valid = (state_q == StDone) && owner_kw_q;
    assign st_out_valid = (state_q == StDone) && !owner_kw_q;
    assign kw_out_data  = kw_res_q;
    assign st_out_data  = st_res_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_sbox_sched.sv
// Bench for sbox_sched: three instances (NUM_SBOX 4, 1, 2), directed vector table, corner
// sequences and a randomized run against a table-based transaction model.
module tb_sbox_sched;

    logic         clk = 1'b0;
    logic         rst          [3];
    logic         st_in_valid  [3];
    logic         st_in_ready  [3];
    logic [127:0] st_in_data   [3];
    logic         st_out_valid [3];
    logic         st_out_ready [3];
    logic [127:0] st_out_data  [3];
    logic         kw_in_valid  [3];
    logic         kw_in_ready  [3];
    logic [31:0]  kw_in_data   [3];
    logic         kw_out_valid [3];
    logic         kw_out_ready [3];
    logic [31:0]  kw_out_data  [3];
    logic         busy         [3];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sbox_sched #(.NUM_SBOX((g == 0) ? 4 : (g == 1) ? 1 : 2)) u_dut (
            .clk          (clk),
            .rst          (rst[g]),
            .st_in_valid  (st_in_valid[g]),
            .st_in_ready  (st_in_ready[g]),
            .st_in_data   (st_in_data[g]),
            .st_out_valid (st_out_valid[g]),
            .st_out_ready (st_out_ready[g]),
            .st_out_data  (st_out_data[g]),
            .kw_in_valid  (kw_in_valid[g]),
            .kw_in_ready  (kw_in_ready[g]),
            .kw_in_data   (kw_in_data[g]),
            .kw_out_valid (kw_out_valid[g]),
            .kw_out_ready (kw_out_ready[g]),
            .kw_out_data  (kw_out_data[g]),
            .busy         (busy[g])
        );
    end

    logic [7:0] sbox_tab [256] = '{
        'h63,'h7c,'h77,'h7b,'hf2,'h6b,'h6f,'hc5,'h30,'h01,'h67,'h2b,'hfe,'hd7,'hab,'h76,
        'hca,'h82,'hc9,'h7d,'hfa,'h59,'h47,'hf0,'had,'hd4,'ha2,'haf,'h9c,'ha4,'h72,'hc0,
        'hb7,'hfd,'h93,'h26,'h36,'h3f,'hf7,'hcc,'h34,'ha5,'he5,'hf1,'h71,'hd8,'h31,'h15,
        'h04,'hc7,'h23,'hc3,'h18,'h96,'h05,'h9a,'h07,'h12,'h80,'he2,'heb,'h27,'hb2,'h75,
        'h09,'h83,'h2c,'h1a,'h1b,'h6e,'h5a,'ha0,'h52,'h3b,'hd6,'hb3,'h29,'he3,'h2f,'h84,
        'h53,'hd1,'h00,'hed,'h20,'hfc,'hb1,'h5b,'h6a,'hcb,'hbe,'h39,'h4a,'h4c,'h58,'hcf,
        'hd0,'hef,'haa,'hfb,'h43,'h4d,'h33,'h85,'h45,'hf9,'h02,'h7f,'h50,'h3c,'h9f,'ha8,
        'h51,'ha3,'h40,'h8f,'h92,'h9d,'h38,'hf5,'hbc,'hb6,'hda,'h21,'h10,'hff,'hf3,'hd2,
        'hcd,'h0c,'h13,'hec,'h5f,'h97,'h44,'h17,'hc4,'ha7,'h7e,'h3d,'h64,'h5d,'h19,'h73,
        'h60,'h81,'h4f,'hdc,'h22,'h2a,'h90,'h88,'h46,'hee,'hb8,'h14,'hde,'h5e,'h0b,'hdb,
        'he0,'h32,'h3a,'h0a,'h49,'h06,'h24,'h5c,'hc2,'hd3,'hac,'h62,'h91,'h95,'he4,'h79,
        'he7,'hc8,'h37,'h6d,'h8d,'hd5,'h4e,'ha9,'h6c,'h56,'hf4,'hea,'h65,'h7a,'hae,'h08,
        'hba,'h78,'h25,'h2e,'h1c,'ha6,'hb4,'hc6,'he8,'hdd,'h74,'h1f,'h4b,'hbd,'h8b,'h8a,
        'h70,'h3e,'hb5,'h66,'h48,'h03,'hf6,'h0e,'h61,'h35,'h57,'hb9,'h86,'hc1,'h1d,'h9e,
        'he1,'hf8,'h98,'h11,'h69,'hd9,'h8e,'h94,'h9b,'h1e,'h87,'he9,'hce,'h55,'h28,'hdf,
        'h8c,'ha1,'h89,'h0d,'hbf,'he6,'h42,'h68,'h41,'h99,'h2d,'h0f,'hb0,'h54,'hbb,'h16
    };

    typedef struct {
        int           dut;
        bit           key;
        logic [127:0] din;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t tab [8];

    function automatic int ns_of(input int k);
        return (k == 0) ? 4 : (k == 1) ? 1 : 2;
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input int nbytes);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < nbytes; j++) r[8*j +: 8] = sbox_tab[d[8*j +: 8]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs(input int k);
        st_in_valid[k]  = 1'b0;
        st_in_data[k]   = '0;
        st_out_ready[k] = 1'b0;
        kw_in_valid[k]  = 1'b0;
        kw_in_data[k]   = '0;
        kw_out_ready[k] = 1'b0;
    endtask

    task automatic reset_dut(input int k);
        @(negedge clk);
        rst[k] = 1'b1;
        kw_in_valid[k] = 1'b1;
        st_in_valid[k] = 1'b1;
        #1;
        chk("rst_kw_in_ready", kw_in_ready[k], 1'b0);
        chk("rst_st_in_ready", st_in_ready[k], 1'b0);
        @(negedge clk);
        chk("rst_busy", busy[k], 1'b0);
        chk("rst_kw_out_valid", kw_out_valid[k], 1'b0);
        chk("rst_st_out_valid", st_out_valid[k], 1'b0);
        chk("rst_kw_out_data", kw_out_data[k], 32'h0);
        chk("rst_st_out_data", st_out_data[k], 128'h0);
        rst[k] = 1'b0;
        idle_inputs(k);
    endtask

    // Counts cycles after the accept edge until the owner's result valid appears.
    task automatic wait_out(input int k, input bit key, output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            chk("nonowner_out_valid", key ? st_out_valid[k] : kw_out_valid[k], 1'b0);
            if (key ? kw_out_valid[k] : st_out_valid[k]) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) chk("out_valid_timeout", key ? kw_out_valid[k] : st_out_valid[k], 1'b1);
    endtask

    task automatic run_op(input int k, input bit key, input logic [127:0] din,
                          output logic [127:0] dout, output int lat);
        @(negedge clk);
        if (key) begin
            kw_in_valid[k] = 1'b1;
            kw_in_data[k]  = din[31:0];
        end else begin
            st_in_valid[k] = 1'b1;
            st_in_data[k]  = din;
        end
        #1;
        chk("op_in_ready", key ? kw_in_ready[k] : st_in_ready[k], 1'b1);
        @(posedge clk);
        #1;
        kw_in_valid[k] = 1'b0;
        st_in_valid[k] = 1'b0;
        wait_out(k, key, lat);
        dout = key ? {96'b0, kw_out_data[k]} : st_out_data[k];
        if (key) kw_out_ready[k] = 1'b1;
        else st_out_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        kw_out_ready[k] = 1'b0;
        st_out_ready[k] = 1'b0;
    endtask

    task automatic rand_run(input int k, input int ncyc);
        bit           active = 1'b0, own_key = 1'b0, rr_key = 1'b1;
        int           left = 0;
        logic [127:0] op = '0, last_st = '0, last_kw = '0;
        bit           kv = 1'b0, sv = 1'b0, k_taken = 1'b0, s_taken = 1'b0;
        logic [31:0]  kd = '0;
        logic [127:0] sd = '0;
        bit           kor, sor, do_rst, gk, gs, done;
        reset_dut(k);
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            do_rst = ($urandom_range(0, 99) == 0);
            if (!kv || k_taken) begin
                kv = $urandom_range(0, 1) == 1;
                kd = $urandom;
            end
            if (!sv || s_taken) begin
                sv = $urandom_range(0, 1) == 1;
                sd = {$urandom, $urandom, $urandom, $urandom};
            end
            kor = $urandom_range(0, 2) != 0;
            sor = $urandom_range(0, 2) != 0;
            rst[k] = do_rst;
            kw_in_valid[k] = kv;
            kw_in_data[k] = kd;
            st_in_valid[k] = sv;
            st_in_data[k] = sd;
            kw_out_ready[k] = kor;
            st_out_ready[k] = sor;
            #1;
            gk = 1'b0;
            gs = 1'b0;
            if (!active && !do_rst) begin
                if (kv && (!sv || rr_key)) gk = 1'b1;
                else if (sv) gs = 1'b1;
            end
            done = active && left == 0;
            chk("rnd_busy", busy[k], active);
            chk("rnd_kw_in_ready", kw_in_ready[k], gk);
            chk("rnd_st_in_ready", st_in_ready[k], gs);
            chk("rnd_kw_out_valid", kw_out_valid[k], done && own_key);
            chk("rnd_st_out_valid", st_out_valid[k], done && !own_key);
            if (!(active && own_key && left > 0)) chk("rnd_kw_out_data", kw_out_data[k], last_kw);
            if (!(active && !own_key && left > 0)) chk("rnd_st_out_data", st_out_data[k], last_st);
            k_taken = gk;
            s_taken = gs;
            if (do_rst) begin
                active = 1'b0;
                rr_key = 1'b1;
                last_kw = '0;
                last_st = '0;
            end else if (active) begin
                if (left > 0) begin
                    left--;
                    if (left == 0) begin
                        if (own_key) last_kw = ref_sub(op, 4);
                        else last_st = ref_sub(op, 16);
                    end
                end else if (own_key ? kor : sor) begin
                    active = 1'b0;
                end
            end else if (gk || gs) begin
                active = 1'b1;
                own_key = gk;
                rr_key = !gk;
                left = (gk ? 4 : 16) / ns_of(k);
                op = gk ? {96'b0, kd} : sd;
            end
        end
        @(negedge clk);
        rst[k] = 1'b1;
        @(negedge clk);
        rst[k] = 1'b0;
        idle_inputs(k);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] res;
        logic [127:0] exp;
        int           lat;
        int           who [4];
        int           cyc [4];
        int           ng;
        logic [7:0]   b;

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            idle_inputs(k);
        end

        tab[0] = '{0, 1'b1, 128'h09cf4f3c, 128'h018a84eb, 2};
        tab[1] = '{0, 1'b0, 128'h0f0e0d0c0b0a09080706050403020100,
                   128'h76abd7fe2b670130c56f6bf27b777c63, 5};
        tab[2] = '{1, 1'b0, 128'h0f0e0d0c0b0a09080706050403020100,
                   128'h76abd7fe2b670130c56f6bf27b777c63, 17};
        tab[3] = '{2, 1'b0, 128'h0f0e0d0c0b0a09080706050403020100,
                   128'h76abd7fe2b670130c56f6bf27b777c63, 9};
        tab[4] = '{1, 1'b1, 128'h00000053, 128'h636363ed, 5};
        tab[5] = '{2, 1'b1, 128'h09cf4f3c, 128'h018a84eb, 3};
        tab[6] = '{0, 1'b1, 128'h00000000, 128'h63636363, 2};
        tab[7] = '{0, 1'b0, {128{1'b1}}, {16{8'h16}}, 5};

        for (int k = 0; k < 3; k++) reset_dut(k);

        for (int i = 0; i < 8; i++) begin
            run_op(tab[i].dut, tab[i].key, tab[i].din, res, lat);
            chk($sformatf("vec%0d_data", i), res, tab[i].exp);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(tab[i].lat));
        end

        // Contention straight after reset: KEY first, then strict alternation.
        reset_dut(0);
        @(negedge clk);
        kw_in_valid[0] = 1'b1;
        kw_in_data[0] = 32'h01020304;
        st_in_valid[0] = 1'b1;
        st_in_data[0] = 128'h00112233445566778899aabbccddeeff;
        kw_out_ready[0] = 1'b1;
        st_out_ready[0] = 1'b1;
        #1;
        chk("cont_first_kw_ready", kw_in_ready[0], 1'b1);
        chk("cont_first_st_ready", st_in_ready[0], 1'b0);
        for (int i = 0; i < 4; i++) begin
            who[i] = -1;
            cyc[i] = -1;
        end
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            if (kw_in_ready[0]) begin
                who[ng] = 0;
                cyc[ng] = c;
                ng++;
            end else if (st_in_ready[0]) begin
                who[ng] = 1;
                cyc[ng] = c;
                ng++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cont_grant%0d_owner", i), 128'(who[i]), 128'(i % 2));
        end
        chk("cont_grant1_cycle", 128'(cyc[1]), 128'd3);
        chk("cont_grant2_cycle", 128'(cyc[2]), 128'd9);
        chk("cont_grant3_cycle", 128'(cyc[3]), 128'd12);
        @(posedge clk);
        #1;
        kw_in_valid[0] = 1'b0;
        st_in_valid[0] = 1'b0;
        for (int c = 0; c < 40 && busy[0]; c++) @(negedge clk);
        chk("cont_drain_idle", busy[0], 1'b0);
        idle_inputs(0);

        // Backpressure on the state result while a key request waits.
        @(negedge clk);
        st_in_valid[0] = 1'b1;
        st_in_data[0] = 128'h00112233445566778899aabbccddeeff;
        exp = ref_sub(128'h00112233445566778899aabbccddeeff, 16);
        @(posedge clk);
        #1;
        st_in_valid[0] = 1'b0;
        kw_in_valid[0] = 1'b1;
        kw_in_data[0] = 32'hc0ffee00;
        wait_out(0, 1'b0, lat);
        for (int c = 0; c < 5; c++) begin
            chk("bp_st_out_valid", st_out_valid[0], 1'b1);
            chk("bp_st_out_data", st_out_data[0], exp);
            chk("bp_busy", busy[0], 1'b1);
            chk("bp_kw_in_ready", kw_in_ready[0], 1'b0);
            @(negedge clk);
        end
        st_out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        st_out_ready[0] = 1'b0;
        @(negedge clk);
        #1;
        chk("bp_valid_dropped", st_out_valid[0], 1'b0);
        chk("bp_kw_granted", kw_in_ready[0], 1'b1);
        @(posedge clk);
        #1;
        kw_in_valid[0] = 1'b0;
        wait_out(0, 1'b1, lat);
        chk("bp_kw_data", kw_out_data[0], ref_sub(128'hc0ffee00, 4));
        kw_out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        kw_out_ready[0] = 1'b0;

        // Reset at beat 7 of a state operation on the single-lane instance.
        @(negedge clk);
        st_in_valid[1] = 1'b1;
        st_in_data[1] = 128'h0f0e0d0c0b0a09080706050403020100;
        @(posedge clk);
        #1;
        st_in_valid[1] = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_busy_before", busy[1], 1'b1);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        chk("midrst_busy_after", busy[1], 1'b0);
        chk("midrst_st_out_data", st_out_data[1], 128'h0);
        chk("midrst_kw_out_data", kw_out_data[1], 32'h0);
        for (int c = 0; c < 20; c++) begin
            chk("midrst_no_st_valid", st_out_valid[1], 1'b0);
            @(negedge clk);
        end
        kw_in_valid[1] = 1'b1;
        st_in_valid[1] = 1'b1;
        #1;
        chk("midrst_rr_key", kw_in_ready[1], 1'b1);
        kw_in_valid[1] = 1'b0;
        st_in_valid[1] = 1'b0;
        run_op(1, 1'b1, 128'h00000053, res, lat);
        chk("midrst_next_data", res, 128'h636363ed);

        // Every byte value through every lane of the key channel.
        for (int w = 0; w < 256; w++) begin
            b = w[7:0];
            exp = {96'b0, b + 8'd192, b + 8'd128, b + 8'd64, b};
            run_op(0, 1'b1, exp, res, lat);
            chk($sformatf("exh_word%0d", w), res, ref_sub(exp, 4));
        end

        for (int k = 0; k < 3; k++) rand_run(k, 1500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
